// File: rtl/conv_pkg.sv
// conv_pkg: tap indices, window slicing helper and default pixel width shared by the 3x3 window path
package conv_pkg;
   localparam int DEF_PIX_W = 4;
   localparam int TAP_TL = 0, TAP_TM = 1, TAP_TR = 2;
   localparam int TAP_ML = 3, TAP_MM = 4, TAP_MR = 5;
   localparam int TAP_BL = 6, TAP_BM = 7, TAP_BR = 8;
   function automatic int tap_slice(input int k, input int pix_w = DEF_PIX_W);
      return k * pix_w;
   endfunction
endpackage

// File: rtl/conv_line_ram.sv
// conv_line_ram: single-port line store, combinational read, synchronous write
module conv_line_ram #(
   parameter int DEPTH = 400,
   parameter int W     = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];
   assign rdata = mem[addr];
   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 neighbourhood generator with valid/ready flow control
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int PIX_W = DEF_PIX_W,
   parameter int IMG_W = 400,
   parameter int IMG_H = 400
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PIX_W-1:0] in_pixel,
   input  logic             in_sof,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [9*PIX_W-1:0] out_window,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sof,
   output logic             out_eol,
   output logic             out_eof,
   output logic             err_sof
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);
   logic [CW-1:0] col, cur_col, nxt_col;
   logic [RW-1:0] row, cur_row, nxt_row;
   logic accept, emit, col_last, row_last;
   logic [PIX_W-1:0] lb0_rd, lb1_rd;
   logic [PIX_W-1:0] win [9];
   // an accepted in_sof forces the beat to position (0,0)
   always_comb begin
      in_ready = !reset && (!out_valid || out_ready);
      accept   = in_valid && in_ready;
      cur_col  = in_sof ? '0 : col;
      cur_row  = in_sof ? '0 : row;
      col_last = cur_col == COL_LAST;
      row_last = cur_row == ROW_LAST;
      emit     = cur_row >= ROW_TWO && cur_col >= COL_TWO;
      nxt_col  = col_last ? '0 : cur_col + 1'b1;
      nxt_row  = col_last ? (row_last ? '0 : cur_row + 1'b1) : cur_row;
   end
   conv_line_ram #(.DEPTH(IMG_W), .W(PIX_W)) lb0 (
      .clk(clk), .we(accept), .addr(cur_col), .wdata(in_pixel), .rdata(lb0_rd)
   );
   conv_line_ram #(.DEPTH(IMG_W), .W(PIX_W)) lb1 (
      .clk(clk), .we(accept), .addr(cur_col), .wdata(lb0_rd), .rdata(lb1_rd)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         row       <= '0;
         col       <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
         err_sof   <= 1'b0;
         for (int k = 0; k < 9; k++) win[k] <= '0;
      end else if (accept) begin
         row          <= nxt_row;
         col          <= nxt_col;
         out_valid    <= emit;
         out_sof      <= emit && cur_row == ROW_TWO && cur_col == COL_TWO;
         out_eol      <= emit && col_last;
         out_eof      <= emit && col_last && row_last;
         err_sof      <= err_sof || (in_sof && (row != '0 || col != '0));
         win[TAP_TL]  <= win[TAP_TM];
         win[TAP_TM]  <= win[TAP_TR];
         win[TAP_TR]  <= lb1_rd;
         win[TAP_ML]  <= win[TAP_MM];
         win[TAP_MM]  <= win[TAP_MR];
         win[TAP_MR]  <= lb0_rd;
         win[TAP_BL]  <= win[TAP_BM];
         win[TAP_BM]  <= win[TAP_BR];
         win[TAP_BR]  <= in_pixel;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
   for (genvar k = 0; k < 9; k++) begin : g_tap
      assign out_window[tap_slice(k, PIX_W) +: PIX_W] = win[k];
   end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed and randomized checks of the 3x3 window stream against an image-array model
module tb_conv_window_gen;
   localparam int PW = 4, W = 5, H = 4;
   logic clk = 0, reset = 1;
   logic [PW-1:0] in_pixel = '0;
   logic in_sof = 0, in_valid = 0, in_ready;
   logic [9*PW-1:0] out_window;
   logic out_valid, out_ready = 0, out_sof, out_eol, out_eof, err_sof;

   conv_window_gen #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .reset(reset), .in_pixel(in_pixel), .in_sof(in_sof), .in_valid(in_valid),
      .in_ready(in_ready), .out_window(out_window), .out_valid(out_valid), .out_ready(out_ready),
      .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .err_sof(err_sof)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [9*PW-1:0] w; logic s, l, f;} exp_t;
   exp_t q[$];
   logic [PW-1:0] img [H][W];
   int mr = 0, mc = 0;
   bit exp_err = 0;
   int tests = 0, fails = 0;
   int win_cnt = 0, sof_cnt = 0, eof_cnt = 0, stall_left = 0;
   logic [9*PW-1:0] first_w, last_w;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_accept(input logic [PW-1:0] p, input bit s);
      exp_t e;
      if (s) begin
         if (mr != 0 || mc != 0) exp_err = 1;
         mr = 0;
         mc = 0;
      end
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               e.w[(3*i+j)*PW +: PW] = img[mr-2+i][mc-2+j];
         e.s = (mr == 2 && mc == 2);
         e.l = (mc == W-1);
         e.f = (mc == W-1 && mr == H-1);
         q.push_back(e);
      end
      if (mc == W-1) begin
         mc = 0;
         mr = (mr == H-1) ? 0 : mr + 1;
      end else mc++;
   endtask

   task automatic cycle(input bit v, input logic [PW-1:0] p, input bit s, input bit r, output bit acc);
      @(negedge clk);
      in_valid = v; in_pixel = p; in_sof = s; out_ready = r;
      #1;
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, q.size() == 0 || r);
      chk("err_sof", err_sof, exp_err);
      if (q.size() != 0) begin
         chk("window", out_window, q[0].w);
         chk("markers", {out_sof, out_eol, out_eof}, {q[0].s, q[0].l, q[0].f});
      end
      if (out_valid && r) begin
         win_cnt++;
         if (out_sof) begin sof_cnt++; first_w = out_window; end
         if (out_eof) begin eof_cnt++; last_w = out_window; end
         if (q.size() != 0) void'(q.pop_front());
      end
      acc = v && in_ready;
      if (acc) model_accept(p, s);
   endtask

   task automatic send(input logic [PW-1:0] p, input bit s, input bit rnd);
      bit acc = 0, v, r;
      int n = 0;
      while (!acc && n < 100) begin
         v = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
         r = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
         if (stall_left > 0 && q.size() != 0 && win_cnt == 1) begin
            r = 0;
            stall_left--;
         end
         cycle(v, p, s, r, acc);
         n++;
      end
      if (!acc) begin fails++; $error("FAIL send_timeout: pixel not accepted in %0d cycles", n); end
   endtask

   task automatic drain();
      bit acc;
      int n = 0;
      while (q.size() != 0 && n < 50) begin cycle(0, '0, 0, 1, acc); n++; end
      if (q.size() != 0) begin fails++; $error("FAIL drain_timeout: %0d windows pending", q.size()); end
      cycle(0, '0, 0, 1, acc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      chk("pre_reset_valid", out_valid, q.size() != 0);
      reset = 1; in_valid = 0; in_sof = 0; out_ready = 0;
      #1;
      chk("reset_in_ready", in_ready, 0);
      @(negedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_window", out_window, 0);
      chk("reset_markers", {out_sof, out_eol, out_eof}, 0);
      chk("reset_err", err_sof, 0);
      reset = 0;
      q.delete();
      mr = 0; mc = 0; exp_err = 0;
   endtask

   task automatic clr_stats();
      win_cnt = 0; sof_cnt = 0; eof_cnt = 0;
   endtask

   int vals_first [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
   int vals_last  [9] = '{7, 8, 9, 12, 13, 14, 1, 2, 3};
   logic [9*PW-1:0] k_first, k_last;

   initial begin
      for (int k = 0; k < 9; k++) begin
         k_first[k*PW +: PW] = PW'(vals_first[k]);
         k_last[k*PW +: PW]  = PW'(vals_last[k]);
      end
      do_reset();
      // directed ramp frame, full throughput
      clr_stats();
      for (int i = 0; i < W*H; i++) send(PW'(((i / W) * 5 + i % W) % 16), i == 0, 0);
      drain();
      chk("ramp_windows", win_cnt, 6);
      chk("ramp_first", first_w, k_first);
      chk("ramp_last", last_w, k_last);
      chk("ramp_eof", eof_cnt, 1);
      // same frame with a 3-cycle downstream stall at the second window
      clr_stats();
      stall_left = 3;
      for (int i = 0; i < W*H; i++) send(PW'(((i / W) * 5 + i % W) % 16), i == 0, 0);
      drain();
      chk("stall_done", stall_left, 0);
      chk("stall_windows", win_cnt, 6);
      chk("stall_first", first_w, k_first);
      // three random back-to-back frames with random handshakes
      clr_stats();
      for (int i = 0; i < 3*W*H; i++) send(PW'($urandom), (i % (W*H)) == 0, 1);
      drain();
      chk("rand_windows", win_cnt, 18);
      chk("rand_sof", sof_cnt, 3);
      chk("rand_eof", eof_cnt, 3);
      chk("rand_err", err_sof, 0);
      // in_sof mid-frame at (1,3): error flag and resync
      clr_stats();
      for (int i = 0; i < W + 3; i++) send(PW'($urandom), i == 0, 0);
      for (int i = 0; i < W*H; i++) send(PW'($urandom), i == 0, 0);
      drain();
      chk("resync_err", err_sof, 1);
      chk("resync_windows", win_cnt, 6);
      chk("resync_sof", sof_cnt, 1);
      // reset while the (2,2) window is pending, then a frame without in_sof
      do_reset();
      for (int i = 0; i < 2*W + 3; i++) send(PW'($urandom), i == 0, 0);
      do_reset();
      clr_stats();
      for (int i = 0; i < W*H; i++) send(PW'($urandom), 0, 0);
      drain();
      chk("post_reset_windows", win_cnt, 6);
      chk("post_reset_sof", sof_cnt, 1);
      chk("post_reset_err", err_sof, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 neighbourhood generator for the convolution datapath. It accepts one pixel per handshake in raster order and keeps the two previous image rows in internal line storage. For every input pixel at row ≥ 2 and column ≥ 2 it emits a full 3x3 window, with valid/ready back-pressure and frame/line markers. It replaces the fixed-width, free-running line-buffer controller with a parametrised, flow-controlled block that feeds the kernel multiply-accumulate stage.

## Interface
- PIX_W, 4: bits per pixel.
- IMG_W, 400: pixels per row (≥ 3).
- IMG_H, 400: rows per frame (≥ 3).
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- in_pixel  input  PIX_W  incoming pixel, raster order.
- in_sof  input  1  marks the first pixel of a frame; qualified by in_valid.
- in_valid  input  1  in_pixel/in_sof valid.
- in_ready  output  1  block accepts a beat this cycle.
- out_window  output  9*PIX_W  tap k occupies bits [(k+1)*PIX_W-1 : k*PIX_W]; k = 3*row + col; k=0 is top-left (oldest row, oldest column); k=8 is bottom-right (newest pixel).
- out_valid  output  1  out_window valid.
- out_ready  input  1  downstream accepts.
- out_sof  output  1  first window of the frame (centre (1,1)).
- out_eol  output  1  last window of a row.
- out_eof  output  1  last window of the frame.
- err_sof  output  1  sticky; in_sof seen mid-frame.

## Operation
- Accept when in_valid && in_ready.
- in_ready = !reset && (!out_valid || out_ready).
- Counters col (0..IMG_W-1) and row (0..IMG_H-1), each $clog2 width.
- On accept, col increments. At IMG_W-1, col wraps to 0 and row increments. At (IMG_H-1, IMG_W-1), both wrap to 0.
- An accepted beat with in_sof is treated as pixel (0,0). Counters update to (0,1).
- If in_sof is accepted while (row,col) ≠ (0,0), set err_sof. err_sof clears only on reset.
- Line storage: two arrays lb0 and lb1, each IMG_W × PIX_W.
  - On accept, read lb0[col] and lb1[col] combinationally.
  - Then write lb1[col] ← old lb0[col] and lb0[col] ← in_pixel, read-before-write at the same address.
- Window register: three rows by three columns.
  - On accept, shift all rows one column left.
  - The new right column is {lb1[col], lb0[col], in_pixel}, top to bottom.
- Emit condition: accepted pixel has row ≥ 2 and col ≥ 2. No windows are emitted for the first two rows or the first two columns.
- Markers, registered with the window:
  - out_sof when (row,col) = (2,2).
  - out_eol when col = IMG_W-1.
  - out_eof when row = IMG_H-1 and col = IMG_W-1.
- Windows per frame: (IMG_W-2)·(IMG_H-2).
- No arithmetic on pixel data; values pass through bit-exact.

## Timing
- Latency: one cycle. The window appears the cycle after the accepting edge of its bottom-right pixel.
- Output is held stable (window and markers) while out_valid && !out_ready.
- out_valid clears when a window is accepted and no new window is produced in the same cycle.
- Accept and out-accept in the same cycle: the new window replaces the old one with no bubble. Throughput is 1 pixel per clock.
- Stalled input (in_valid low) changes no state. out_valid persists until it is consumed.
- Reset values: out_valid 0, out_window 0, out_sof/out_eol/out_eof 0, err_sof 0, row/col 0, in_ready 0 while reset is high.
- Line-buffer contents are not reset. They are never exposed, because windows require row ≥ 2.
- Reset mid-frame: any pending window is dropped. The next accepted beat is (0,0) regardless of in_sof.

## Structure
- Shared package conv_pkg holds:
  - the tap index constants TAP_TL = 0 … TAP_BR = 8;
  - a function tap_slice(k) for the window bit range;
  - the default PIX_W.
- One sub-module: conv_line_ram, a single-port IMG_W × PIX_W array with combinational read and synchronous write. It is instantiated twice, as lb0 and lb1.
- Counters, window register, markers and handshake live in the top level.

## Test plan
- IMG_W=5, IMG_H=4, PIX_W=4; pixel = (5r+c) mod 16; in_valid held high and out_ready high → 6 windows.
  - First window taps k0..k8 = 0,1,2,5,6,7,10,11,12, with out_sof=1.
  - Last window = 7,8,9,12,13,14,1,2,3 (values mod 16), with out_eol=1 and out_eof=1.
- Same frame with out_ready low for 3 cycles at the second window → out_window is held unchanged and in_ready=0 for those cycles. No window is lost or duplicated; the total is still 6.
- Random in_valid/out_ready (50% duty), 3 back-to-back frames → the window sequence matches the reference model. out_sof count = 3, out_eof count = 3, err_sof stays 0.
- in_sof asserted at pixel (1,3) → err_sof=1. The next windows start 2 rows later with out_sof, and taps are computed from the resynced frame.
- reset pulsed for 1 cycle at pixel (2,3) while out_valid=1 → out_valid=0 in the next cycle. A full new frame then yields exactly 6 correct windows, and err_sof=0.
